// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: sequential prefetch buffer between the core's
// combinational fetch port and a req/ack instruction memory.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc_i, ce_i        core fetch address and enable
//   inst_o            instruction for pc_i (valid on ce_i & !stall_req_o)
//   stall_req_o       core must hold pc_i
//   mem_req_o         registered request, held until mem_ack_i
//   mem_addr_o        registered request address
//   mem_ack_i         one-cycle response strobe
//   mem_rdata_i       response data, valid with mem_ack_i
module inst_fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              stall_req_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] fetch_addr;
  logic              discard;

  logic              empty;
  logic              ack_v;
  logic              head_hit;
  logic              byp_hit;
  logic              miss;
  logic              redirect;
  logic              push;
  logic              pop;
  logic              issue;
  logic [ADDR_W-1:0] pend_addr;
  logic [PW:0]       occ;

  // an ack with no request outstanding is not a response
  assign ack_v    = mem_ack_i & (state == REQ);
  assign empty    = (count == '0);
  assign head_hit = ce_i & ~empty & (tag_q[rd_ptr] == pc_i);
  assign byp_hit  = ce_i & empty & ack_v & ~discard
                  & (mem_addr_o == pc_i);
  assign miss     = ce_i & ~head_hit & ~byp_hit;

  // the address that will arrive next without intervention
  assign pend_addr = (state == REQ && !discard) ? mem_addr_o
                                                : fetch_addr;

  assign redirect = miss & ~(empty & (pc_i == pend_addr));
  assign pop      = head_hit;
  assign push     = ack_v & ~discard & ~byp_hit & ~redirect;
  assign occ      = count - (PW+1)'(pop);

  // a request reserves its slot up front, so a push never overflows
  assign issue = (state == IDLE) & ce_i & ~redirect & ~discard
               & (occ < (PW+1)'(DEPTH));

  always_comb begin
    inst_o = '0;
    if (head_hit) begin
      inst_o = data_q[rd_ptr];
    end else if (byp_hit) begin
      inst_o = mem_rdata_i;
    end
  end

  assign stall_req_o = miss;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      tag_q[wr_ptr]  <= mem_addr_o;
      data_q[wr_ptr] <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fetch_addr <= '0;
      discard    <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      if (redirect) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        fetch_addr <= pc_i;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end

      // the in-flight word belongs to the old stream
      if (redirect && state == REQ && !mem_ack_i) begin
        discard <= 1'b1;
      end else if (ack_v && discard) begin
        discard <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (issue) begin
            state      <= REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= fetch_addr;
            fetch_addr <= fetch_addr + ADDR_W'(4);
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: randomized bench for inst_fetch_buffer with
// a queue-based reference model and a latency-programmable memory.
module tb_inst_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic [31:0] inst_o;
  logic        stall_req_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  inst_fetch_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .inst_o     (inst_o),
    .stall_req_o(stall_req_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // memory side
  int          lat = 1;
  int          wcnt = 1;
  logic        spur_en = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] reqlog[$];

  // reference model: buffered addresses oldest first, one request slot
  logic [31:0] m_q[$];
  logic        m_req = 1'b0;
  logic        m_disc = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_fetch = '0;
  logic        e_stall = 1'b0;
  logic [31:0] e_inst = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic void model_comb();
    logic ackv, hh, bh;
    ackv = mem_ack_i && m_req;
    hh = ce_i && m_q.size() > 0 && m_q[0] == pc_i;
    bh = ce_i && m_q.size() == 0 && ackv && !m_disc && m_addr == pc_i;
    e_stall = ce_i && !(hh || bh);
    e_inst = (hh || bh) ? word(pc_i) : 32'h0;
  endfunction

  function automatic void model_update();
    logic ackv, hh, bh, miss, redir, iss, req0;
    logic [31:0] pend, f0;
    if (rst) begin
      m_q.delete();
      m_req = 0; m_disc = 0; m_addr = 0; m_fetch = 0;
      return;
    end
    req0 = m_req;
    f0 = m_fetch;
    ackv = mem_ack_i && m_req;
    hh = ce_i && m_q.size() > 0 && m_q[0] == pc_i;
    bh = ce_i && m_q.size() == 0 && ackv && !m_disc && m_addr == pc_i;
    miss = ce_i && !hh && !bh;
    pend = (m_req && !m_disc) ? m_addr : m_fetch;
    redir = miss && !(m_q.size() == 0 && pc_i == pend);
    iss = !m_req && ce_i && !redir && !m_disc
        && (m_q.size() - int'(hh)) < DEPTH;
    if (hh) void'(m_q.pop_front());
    if (redir) begin
      m_q.delete();
      m_fetch = pc_i;
    end
    if (ackv) begin
      if (m_disc) m_disc = 0;
      else if (!bh && !redir) m_q.push_back(m_addr);
      m_req = 0;
    end
    if (redir && req0 && !mem_ack_i) m_disc = 1;
    if (iss) begin
      m_req = 1;
      m_addr = f0;
      m_fetch = f0 + 32'd4;
    end
  endfunction

  // called just after a rising edge; returns at the falling edge
  task automatic drive(input logic r, input logic c, input logic [31:0] p);
    rst = r; ce_i = c; pc_i = p;
    mem_ack_i = 1'b0;
    mem_rdata_i = $urandom;
    if (mem_req_o === 1'b1) begin
      if (wcnt <= 0) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = word(mem_addr_o);
        reqlog.push_back(mem_addr_o);
        wcnt = lat;
      end else begin
        wcnt--;
      end
    end else if (force_ack || (spur_en && $urandom_range(0, 7) == 0)) begin
      mem_ack_i = 1'b1;
    end
    if (r) wcnt = lat;
    model_comb();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    reqlog.delete();
  endtask

  task automatic test_reset();
    lat = 1;
    do_reset();
    drive(0, 0, 0);
    checks++;
    if ({inst_o, stall_req_o, mem_req_o, mem_addr_o} !== 66'h0) begin
      errors++;
      $display("FAIL reset got inst=%h stall=%b req=%b addr=%h exp all 0",
               inst_o, stall_req_o, mem_req_o, mem_addr_o);
    end
    tick();
    drive(0, 0, 32'h40);
    checks++;
    if (mem_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got req=%b stall=%b exp 0 0",
               mem_req_o, stall_req_o);
    end
    tick();
  endtask

  task automatic test_cold_start();
    int first_hit = -1;
    lat = 2;
    do_reset();
    for (int i = 0; i < 16 && first_hit < 0; i++) begin
      drive(0, 1, 0);
      checks++;
      if ({inst_o, stall_req_o, mem_req_o, mem_addr_o}
          !== {e_inst, e_stall, m_req, m_addr}) begin
        errors++;
        $display("FAIL cold cyc=%0d got %h %b %b %h exp %h %b %b %h", i,
                 inst_o, stall_req_o, mem_req_o, mem_addr_o,
                 e_inst, e_stall, m_req, m_addr);
      end
      if (i == 1) begin
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
          errors++;
          $display("FAIL cold_req got req=%b addr=%h exp 1 0",
                   mem_req_o, mem_addr_o);
        end
      end
      if (stall_req_o === 1'b0) begin
        first_hit = i;
        checks++;
        if (inst_o !== word(0)) begin
          errors++;
          $display("FAIL cold_byp got %h exp %h", inst_o, word(0));
        end
      end
      tick();
    end
    checks++;
    if (first_hit != 3) begin
      errors++;
      $display("FAIL cold_lat got %0d exp 3", first_hit);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc = 0;
    int served = 0;
    lat = 1;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      drive(0, 1, pc);
      checks++;
      if ({inst_o, stall_req_o, mem_req_o, mem_addr_o}
          !== {e_inst, e_stall, m_req, m_addr}) begin
        errors++;
        $display("FAIL stream cyc=%0d got %h %b %b %h exp %h %b %b %h", i,
                 inst_o, stall_req_o, mem_req_o, mem_addr_o,
                 e_inst, e_stall, m_req, m_addr);
      end
      if (!e_stall) begin
        pc += 4;
        served++;
      end
      tick();
    end
    checks++;
    if (served < 10 || reqlog.size() < 10) begin
      errors++;
      $display("FAIL stream_rate got served=%0d reqs=%0d exp >=10",
               served, reqlog.size());
    end
    foreach (reqlog[k]) begin
      checks++;
      if (reqlog[k] !== 32'(k * 4)) begin
        errors++;
        $display("FAIL stream_order idx=%0d got %h exp %h",
                 k, reqlog[k], 32'(k * 4));
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] pc = 0;
    logic found = 0, seen_next = 0, done = 0;
    lat = 3;
    do_reset();
    for (int i = 0; i < 200 && !done; i++) begin
      if (!found && mem_req_o === 1'b1 && mem_addr_o === 32'h10) begin
        found = 1;
        pc = 32'h100;
        drive(0, 1, pc);
        checks++;
        if (stall_req_o !== 1'b1) begin
          errors++;
          $display("FAIL redir_stall got %b exp 1", stall_req_o);
        end
      end else begin
        drive(0, 1, pc);
      end
      checks++;
      if ({inst_o, stall_req_o, mem_req_o, mem_addr_o}
          !== {e_inst, e_stall, m_req, m_addr}) begin
        errors++;
        $display("FAIL redir cyc=%0d got %h %b %b %h exp %h %b %b %h", i,
                 inst_o, stall_req_o, mem_req_o, mem_addr_o,
                 e_inst, e_stall, m_req, m_addr);
      end
      if (found && !seen_next && mem_req_o === 1'b1
          && mem_addr_o !== 32'h10) begin
        seen_next = 1;
        checks++;
        if (mem_addr_o !== 32'h100) begin
          errors++;
          $display("FAIL redir_addr got %h exp 00000100", mem_addr_o);
        end
      end
      if (found && stall_req_o === 1'b0) begin
        done = 1;
        checks++;
        if (inst_o !== word(32'h100) || !seen_next) begin
          errors++;
          $display("FAIL redir_inst got %h seen=%b exp %h",
                   inst_o, seen_next, word(32'h100));
        end
      end
      if (!found && !e_stall) pc += 4;
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL redir_timeout got found=%b done=%b exp 1 1",
               found, done);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pc = 32'hFFFF_FFF8;
    lat = 1;
    do_reset();
    drive(0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, pc);
      checks++;
      if ({inst_o, stall_req_o, mem_req_o, mem_addr_o}
          !== {e_inst, e_stall, m_req, m_addr}) begin
        errors++;
        $display("FAIL wrap cyc=%0d got %h %b %b %h exp %h %b %b %h", i,
                 inst_o, stall_req_o, mem_req_o, mem_addr_o,
                 e_inst, e_stall, m_req, m_addr);
      end
      if (!e_stall) pc += 4;
      tick();
    end
    checks++;
    if (reqlog.size() < 3) begin
      errors++;
      $display("FAIL wrap_count got %0d exp >=3", reqlog.size());
    end else if (reqlog[0] !== 32'hFFFF_FFF8 || reqlog[1] !== 32'hFFFF_FFFC
                 || reqlog[2] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_order got %h %h %h exp fffffff8 fffffffc 0",
               reqlog[0], reqlog[1], reqlog[2]);
    end
  endtask

  task automatic test_midreset();
    logic [31:0] pc = 0;
    logic hit = 0;
    lat = 10;
    do_reset();
    for (int i = 0; i < 10 && mem_req_o !== 1'b1; i++) begin
      drive(0, 1, 0); tick();
    end
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_req got %b exp 1", mem_req_o);
    end
    drive(1, 1, 0); tick();
    force_ack = 1;
    drive(0, 0, 0);
    force_ack = 0;
    checks++;
    if ({inst_o, stall_req_o, mem_req_o, mem_addr_o} !== 66'h0) begin
      errors++;
      $display("FAIL midrst_out got %h %b %b %h exp all 0",
               inst_o, stall_req_o, mem_req_o, mem_addr_o);
    end
    tick();
    lat = 1;
    wcnt = 1;
    reqlog.delete();
    for (int i = 0; i < 12 && !hit; i++) begin
      drive(0, 1, pc);
      checks++;
      if ({inst_o, stall_req_o, mem_req_o, mem_addr_o}
          !== {e_inst, e_stall, m_req, m_addr}) begin
        errors++;
        $display("FAIL midrst cyc=%0d got %h %b %b %h exp %h %b %b %h", i,
                 inst_o, stall_req_o, mem_req_o, mem_addr_o,
                 e_inst, e_stall, m_req, m_addr);
      end
      if (stall_req_o === 1'b0) hit = 1;
      tick();
    end
    checks++;
    if (!hit || reqlog.size() < 1 || reqlog[0] !== 32'h0) begin
      errors++;
      $display("FAIL midrst_restart got hit=%b reqs=%0d exp hit at 0",
               hit, reqlog.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] pc = 0;
    logic c, r;
    lat = 1;
    do_reset();
    spur_en = 1;
    for (int i = 0; i < 600; i++) begin
      lat = $urandom_range(0, 3);
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 11) == 0) begin
        pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                         : {24'h0, 6'($urandom), 2'b00};
      end
      drive(r, c, pc);
      checks++;
      if ({inst_o, stall_req_o, mem_req_o, mem_addr_o}
          !== {e_inst, e_stall, m_req, m_addr}) begin
        errors++;
        $display("FAIL random cyc=%0d got %h %b %b %h exp %h %b %b %h", i,
                 inst_o, stall_req_o, mem_req_o, mem_addr_o,
                 e_inst, e_stall, m_req, m_addr);
      end
      if (c && !e_stall) pc += 4;
      tick();
      checks++;
      if (m_q.size() > DEPTH) begin
        errors++;
        $display("FAIL random_occ got %0d exp <=%0d", m_q.size(), DEPTH);
      end
    end
    spur_en = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_cold_start();
    test_stream();
    test_redirect();
    test_wrap();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
